// File: rtl/snake_body_queue.sv
// Circular store of snake body segment positions, head to tail, with a registered random-read port.
// Optional SELF_HIT_EN macro adds a self_hit pulse when a pushed position is already occupied.
`timescale 1ns/1ps
module snake_body_queue #(
   parameter int POS_W = 12,
   parameter int DEPTH = 64,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [POS_W-1:0] pos_in,
   input  logic             push,
   input  logic             pop,
   output logic [POS_W-1:0] pos_out,
   output logic             pos_out_valid,
   output logic [POS_W-1:0] head_pos,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [POS_W-1:0] rd_pos,
   output logic             rd_valid,
   output logic             overflow,
   output logic             underflow
`ifdef SELF_HIT_EN
   ,
   output logic             self_hit
`endif
);

   logic [POS_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0] head_ptr;
   logic [IDX_W-1:0] tail_ptr;
   logic [IDX_W-1:0] wr_ptr;
   logic [IDX_W-1:0] rd_ptr;
   logic             push_ok;
   logic             pop_ok;
   logic             rd_hit;
   logic [CNT_W-1:0] count_nxt;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign wr_ptr  = head_ptr + IDX_W'(1);
   assign rd_ptr  = head_ptr - rd_idx;
   assign rd_hit  = (CNT_W'(rd_idx) < count);
   assign pop_ok  = pop && !empty;
   // a move step frees the tail slot, so a push is legal while full
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      count_nxt = count;
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= pos_in;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_ptr      <= '0;
         tail_ptr      <= '0;
         count         <= '0;
         pos_out       <= '0;
         pos_out_valid <= 1'b0;
         head_pos      <= '0;
         rd_pos        <= '0;
         rd_valid      <= 1'b0;
         overflow      <= 1'b0;
         underflow     <= 1'b0;
      end else begin
         pos_out_valid <= pop_ok;
         if (pop_ok) begin
            pos_out  <= mem[tail_ptr];
            tail_ptr <= tail_ptr + IDX_W'(1);
         end else if (push_ok && empty) begin
            // first segment of an empty body is also its tail
            tail_ptr <= wr_ptr;
         end
         if (push_ok) begin
            head_ptr <= wr_ptr;
            head_pos <= pos_in;
         end
         count    <= count_nxt;
         rd_valid <= rd_hit;
         rd_pos   <= rd_hit ? mem[rd_ptr] : '0;
         if (push && !push_ok) overflow  <= 1'b1;
         if (pop && !pop_ok)   underflow <= 1'b1;
      end
   end

`ifdef SELF_HIT_EN
   logic [DEPTH-1:0] occ;
   logic [DEPTH-1:0] hit_vec;

   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_vec[i] = occ[i] && (mem[i] == pos_in) &&
                      !(pop_ok && (IDX_W'(i) == tail_ptr));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         occ      <= '0;
         self_hit <= 1'b0;
      end else begin
         // set after clear: a full move step reuses the tail slot
         if (pop_ok)  occ[tail_ptr] <= 1'b0;
         if (push_ok) occ[wr_ptr]   <= 1'b1;
         self_hit <= push_ok && (|hit_vec);
      end
   end
`endif

endmodule

// File: tb/tb_snake_body_queue.sv
// Directed self-checking bench for snake_body_queue (DEPTH=64, POS_W=12).
`timescale 1ns/1ps
module tb_snake_body_queue;

   localparam int POS_W = 12;
   localparam int DEPTH = 64;
   localparam int CNT_W = 7;
   localparam int IDX_W = 6;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [POS_W-1:0] pos_in = '0;
   logic             push = 1'b0;
   logic             pop = 1'b0;
   logic [POS_W-1:0] pos_out;
   logic             pos_out_valid;
   logic [POS_W-1:0] head_pos;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             empty;
   logic [IDX_W-1:0] rd_idx = '0;
   logic [POS_W-1:0] rd_pos;
   logic             rd_valid;
   logic             overflow;
   logic             underflow;
`ifdef SELF_HIT_EN
   logic             self_hit;
`endif

   int passed = 0;
   int total  = 0;

   snake_body_queue #(.POS_W(POS_W), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .pos_in(pos_in),
      .push(push),
      .pop(pop),
      .pos_out(pos_out),
      .pos_out_valid(pos_out_valid),
      .head_pos(head_pos),
      .count(count),
      .full(full),
      .empty(empty),
      .rd_idx(rd_idx),
      .rd_pos(rd_pos),
      .rd_valid(rd_valid),
      .overflow(overflow),
      .underflow(underflow)
`ifdef SELF_HIT_EN
      ,
      .self_hit(self_hit)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   task automatic step(input logic p, input logic q,
                       input logic [POS_W-1:0] v,
                       input logic [IDX_W-1:0] idx);
      push   = p;
      pop    = q;
      pos_in = v;
      rd_idx = idx;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic do_reset();
      push   = 1'b0;
      pop    = 1'b0;
      pos_in = '0;
      rd_idx = '0;
      reset  = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [12:0] flags;
      do_reset();
      flags = {count, empty, full, pos_out_valid, rd_valid, overflow, underflow};
      if (flags !== 13'b0000000_1_0_0_0_0_0) begin
         $display("FAIL reset_flags: got %b required %b", flags,
                  13'b0000000_1_0_0_0_0_0);
      end else passed++;
      total++;
      if ({pos_out, head_pos, rd_pos} !== 36'h0) begin
         $display("FAIL reset_data: got %h required 0",
                  {pos_out, head_pos, rd_pos});
      end else passed++;
      total++;
   endtask

   task automatic test_push_read();
      logic [POS_W-1:0] exp_rd [4];
      exp_rd = '{12'h103, 12'h102, 12'h101, 12'h000};
      step(1, 0, 12'h101, 0);
      step(1, 0, 12'h102, 0);
      step(1, 0, 12'h103, 0);
      if (count !== 7'd3 || head_pos !== 12'h103 || empty !== 1'b0) begin
         $display("FAIL push3: got count=%0d head=%h empty=%b required 3 103 0",
                  count, head_pos, empty);
      end else passed++;
      total++;
      for (int j = 0; j < 4; j++) begin
         step(0, 0, 0, IDX_W'(j));
         if (rd_pos !== exp_rd[j] || rd_valid !== (j < 3)) begin
            $display("FAIL read_idx%0d: got %h/%b required %h/%b", j,
                     rd_pos, rd_valid, exp_rd[j], j < 3);
         end else passed++;
         total++;
      end
   endtask

   task automatic test_move();
      step(1, 1, 12'h104, 0);
      if (pos_out !== 12'h101 || pos_out_valid !== 1'b1 ||
          count !== 7'd3 || head_pos !== 12'h104) begin
         $display("FAIL move: got %h/%b/%0d/%h required 101/1/3/104",
                  pos_out, pos_out_valid, count, head_pos);
      end else passed++;
      total++;
      step(0, 0, 0, 0);
      if (pos_out_valid !== 1'b0 || pos_out !== 12'h101) begin
         $display("FAIL move_pulse: got %b/%h required 0/101",
                  pos_out_valid, pos_out);
      end else passed++;
      total++;
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1, 0, 12'h200 + 12'(i), 0);
      if (count !== 7'd64 || full !== 1'b1 || overflow !== 1'b0) begin
         $display("FAIL fill: got %0d/%b/%b required 64/1/0",
                  count, full, overflow);
      end else passed++;
      total++;
      step(1, 0, 12'hFFF, 0);
      if (count !== 7'd64 || full !== 1'b1 || overflow !== 1'b1 ||
          head_pos !== 12'h23F) begin
         $display("FAIL overflow: got %0d/%b/%b/%h required 64/1/1/23f",
                  count, full, overflow, head_pos);
      end else passed++;
      total++;
      step(1, 1, 12'h300, 0);
      if (pos_out !== 12'h200 || pos_out_valid !== 1'b1 ||
          count !== 7'd64 || head_pos !== 12'h300) begin
         $display("FAIL full_move: got %h/%b/%0d/%h required 200/1/64/300",
                  pos_out, pos_out_valid, count, head_pos);
      end else passed++;
      total++;
      step(0, 0, 0, 63);
      if (rd_pos !== 12'h201 || rd_valid !== 1'b1) begin
         $display("FAIL full_tail_read: got %h/%b required 201/1",
                  rd_pos, rd_valid);
      end else passed++;
      total++;
   endtask

   task automatic test_empty();
      do_reset();
      step(0, 1, 0, 0);
      if (underflow !== 1'b1 || pos_out_valid !== 1'b0 ||
          count !== 7'd0 || empty !== 1'b1) begin
         $display("FAIL underflow: got %b/%b/%0d/%b required 1/0/0/1",
                  underflow, pos_out_valid, count, empty);
      end else passed++;
      total++;
      step(1, 1, 12'h055, 0);
      if (count !== 7'd1 || head_pos !== 12'h055 || pos_out_valid !== 1'b0) begin
         $display("FAIL empty_move: got %0d/%h/%b required 1/055/0",
                  count, head_pos, pos_out_valid);
      end else passed++;
      total++;
      step(0, 1, 0, 0);
      if (pos_out !== 12'h055 || pos_out_valid !== 1'b1 || empty !== 1'b1) begin
         $display("FAIL empty_pop: got %h/%b/%b required 055/1/1",
                  pos_out, pos_out_valid, empty);
      end else passed++;
      total++;
   endtask

   task automatic test_wrap();
      int errs;
      do_reset();
      for (int k = 0; k < 5; k++) step(1, 0, 12'h100 + 12'(k), 0);
      for (int k = 5; k < 205; k++) begin
         step(1, 1, 12'h100 + 12'(k), IDX_W'(k % 5));
         if (pos_out !== 12'h100 + 12'(k - 5) || pos_out_valid !== 1'b1) begin
            $display("FAIL wrap_pop%0d: got %h/%b required %h/1", k,
                     pos_out, pos_out_valid, 12'h100 + 12'(k - 5));
         end else passed++;
         total++;
         if (rd_pos !== 12'h100 + 12'(k - 1 - (k % 5)) || rd_valid !== 1'b1) begin
            $display("FAIL wrap_rd%0d: got %h/%b required %h/1", k,
                     rd_pos, rd_valid, 12'h100 + 12'(k - 1 - (k % 5)));
         end else passed++;
         total++;
      end
      errs = 0;
      for (int j = 0; j < 5; j++) begin
         step(0, 0, 0, IDX_W'(j));
         if (rd_pos !== 12'h100 + 12'(204 - j)) errs++;
      end
      if (errs != 0 || count !== 7'd5) begin
         $display("FAIL wrap_walk: got errs=%0d count=%0d required 0/5",
                  errs, count);
      end else passed++;
      total++;
   endtask

   task automatic test_async_reset();
      logic [12:0] flags;
      do_reset();
      for (int k = 0; k < 11; k++) step(1, 0, 12'h300 + 12'(k), 0);
      step(0, 1, 0, 3);
      if (pos_out_valid !== 1'b1 || count !== 7'd10) begin
         $display("FAIL pre_reset: got %b/%0d required 1/10",
                  pos_out_valid, count);
      end else passed++;
      total++;
      #1;
      reset = 1'b1;
      #1;
      flags = {count, empty, full, pos_out_valid, rd_valid, overflow, underflow};
      if (flags !== 13'b0000000_1_0_0_0_0_0) begin
         $display("FAIL async_reset_flags: got %b required %b", flags,
                  13'b0000000_1_0_0_0_0_0);
      end else passed++;
      total++;
      if ({pos_out, head_pos, rd_pos} !== 36'h0) begin
         $display("FAIL async_reset_data: got %h required 0",
                  {pos_out, head_pos, rd_pos});
      end else passed++;
      total++;
`ifdef SELF_HIT_EN
      if (self_hit !== 1'b0) begin
         $display("FAIL async_reset_hit: got %b required 0", self_hit);
      end else passed++;
      total++;
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

`ifdef SELF_HIT_EN
   task automatic test_self_hit();
      do_reset();
      step(1, 0, 12'h0A1, 0);
      step(1, 0, 12'h0A2, 0);
      step(1, 0, 12'h0A3, 0);
      if (self_hit !== 1'b0) begin
         $display("FAIL hit_new: got %b required 0", self_hit);
      end else passed++;
      total++;
      step(1, 0, 12'h0A2, 0);
      if (self_hit !== 1'b1) begin
         $display("FAIL hit_body: got %b required 1", self_hit);
      end else passed++;
      total++;
      step(1, 1, 12'h0A1, 0);
      if (self_hit !== 1'b0) begin
         $display("FAIL hit_tail_excl: got %b required 0", self_hit);
      end else passed++;
      total++;
      step(1, 1, 12'h0A3, 0);
      if (self_hit !== 1'b1) begin
         $display("FAIL hit_move: got %b required 1", self_hit);
      end else passed++;
      total++;
   endtask
`endif

   initial begin
      test_reset();
      test_push_read();
      test_move();
      test_full();
      test_empty();
      test_wrap();
      test_async_reset();
`ifdef SELF_HIT_EN
      test_self_hit();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
